// File: rtl/sub64_seq_pkg.sv
// sub64_seq_pkg
// Shared definitions for the sequential 64-bit subtractor.
//   - slice width / slice count defaults
//   - FSM state encoding
//   - NZCV bit positions inside the flags register
//   - CLA group width used by the 16-bit slice
package sub64_seq_pkg;

  localparam int SLICE_W_DEF  = 16;
  localparam int N_SLICES_DEF = 4;

  // Lookahead group width inside the 16-bit slice (4 groups of 4 bits).
  localparam int CLA_GRP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the ARM flags in the packed NZCV register.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/sub64_seq_sub16_slice.sv
// sub16_slice
// Combinational 16-bit a + ~b + cin built from four 4-bit lookahead groups.
// Group propagate/generate feed a lookahead carry network; carries inside
// each group are then derived from the group carry-in.
// Ports:
//   i_a, i_b  16-bit operands (i_b is inverted internally)
//   i_cin     carry-in (1 = no borrow)
//   o_sum     16-bit result
//   o_cout    carry-out of bit 15
//   o_c15     carry into bit 15 (used for signed overflow)
module sub16_slice
  import sub64_seq_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_c15
);

  localparam int N_GRP = 16 / CLA_GRP_W;

  logic [15:0]      w_p;
  logic [15:0]      w_g;
  logic [N_GRP-1:0] w_gp;
  logic [N_GRP-1:0] w_gg;
  logic [N_GRP:0]   w_gc;
  logic [15:0]      w_c;

  assign w_p = i_a ^ ~i_b;
  assign w_g = i_a & ~i_b;

  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int j = 0; j < N_GRP; j++) begin
      w_gp[j] = &w_p[j*CLA_GRP_W +: CLA_GRP_W];
      w_gg[j] = w_g[j*4+3]
              | (w_p[j*4+3] & w_g[j*4+2])
              | (w_p[j*4+3] & w_p[j*4+2] & w_g[j*4+1])
              | (w_p[j*4+3] & w_p[j*4+2] & w_p[j*4+1] & w_g[j*4]);
    end
  end

  // Second-level lookahead across the four groups.
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  // Bit carries within each group start from that group's lookahead carry.
  always_comb begin
    logic v_c;
    w_c = '0;
    v_c = 1'b0;
    for (int j = 0; j < N_GRP; j++) begin
      v_c = w_gc[j];
      for (int i = 0; i < CLA_GRP_W; i++) begin
        w_c[j*CLA_GRP_W+i] = v_c;
        v_c = w_g[j*CLA_GRP_W+i] | (w_p[j*CLA_GRP_W+i] & v_c);
      end
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[N_GRP];
  assign o_c15  = w_c[15];

endmodule

// File: rtl/sub64_seq.sv
// sub64_seq
// Sequential 64-bit subtractor with ARM NZCV flags. One 16-bit slice is
// computed per cycle; the operation takes four RUN beats and the result
// is presented over a valid/ready handshake.
// Build option: SUB64_SBC_EN adds the cin port (SBC: a - b - 1 + cin);
// without it the initial carry is constant 1 (plain subtract).
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   operand handshake
//   a, b                  minuend, subtrahend
//   cin                   SBC carry-in (SUB64_SBC_EN builds only)
//   out_valid / out_ready result handshake
//   d                     difference
//   flag_n/z/c/v          NZCV, C = NOT borrow
//
// state | meaning
// IDLE  | ready for operands
// RUN   | computing slice k, one per cycle
// DONE  | result and flags held until consumed
module sub64_seq
  import sub64_seq_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
`ifdef SUB64_SBC_EN
  input  logic        cin,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] d,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  localparam int DATA_W = SLICE_W * N_SLICES;
  localparam int K_W    = $clog2(N_SLICES);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_SLICES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K_W-1:0]      r_k;
  logic                r_carry;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_d;
  logic [3:0]          r_flags;

  logic                w_init_carry;
  logic                w_accept;
  logic                w_last;
  logic [SLICE_W-1:0]  w_sum;
  logic                w_cout;
  logic                w_c15;
  logic                w_zero;

`ifdef SUB64_SBC_EN
  assign w_init_carry = cin;
`else
  assign w_init_carry = 1'b1;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_k == K_LAST);

  // Operands are shifted right each beat, so slice k always sits in the
  // low SLICE_W bits and no variable part-select is needed.
  sub16_slice u_slice (
    .i_a   (r_a[SLICE_W-1:0]),
    .i_b   (r_b[SLICE_W-1:0]),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout),
    .o_c15 (w_c15)
  );

  // On the last beat r_d[DATA_W-1:SLICE_W] holds slices 0..N-2.
  assign w_zero = (w_sum == '0) && (r_d[DATA_W-1:SLICE_W] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_k     <= '0;
            r_carry <= w_init_carry;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_d     <= {w_sum, r_d[DATA_W-1:SLICE_W]};
          r_carry <= w_cout;
          r_k     <= r_k + K_W'(1);
          if (w_last) begin
            r_flags[FLAG_N] <= w_sum[SLICE_W-1];
            r_flags[FLAG_Z] <= w_zero;
            r_flags[FLAG_C] <= w_cout;
            r_flags[FLAG_V] <= w_c15 ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign d      = r_d;
  assign flag_n = r_flags[FLAG_N];
  assign flag_z = r_flags[FLAG_Z];
  assign flag_c = r_flags[FLAG_C];
  assign flag_v = r_flags[FLAG_V];

endmodule

// File: tb/tb_sub64_seq.sv
module tb_sub64_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d;
  logic        flag_n, flag_z, flag_c, flag_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sub64_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef SUB64_SBC_EN
    .cin      (cin),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  // Presents one operand pair, then scrambles the inputs and waits for
  // out_valid. lat = edges from accept to out_valid, -1 on timeout.
  task automatic run_op(input logic [63:0] va, input logic [63:0] vb,
                        input logic vcin, output int lat);
    @(negedge clk);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (d !== 64'd0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: d=%h nzcv=%b required 0/0000", d,
               {flag_n, flag_z, flag_c, flag_v});
    end
  endtask

  task automatic test_basic();
    logic [63:0] ta [5];
    logic [63:0] tb [5];
    logic [63:0] td [5];
    logic [3:0]  tf [5];
    int lat;
    ta[0] = 64'd5;                   tb[0] = 64'd3;
    td[0] = 64'd2;                   tf[0] = 4'b0010;
    ta[1] = 64'd3;                   tb[1] = 64'd5;
    td[1] = 64'hFFFF_FFFF_FFFF_FFFE; tf[1] = 4'b1000;
    ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'd1;
    td[2] = 64'h7FFF_FFFF_FFFF_FFFF; tf[2] = 4'b0011;
    ta[3] = 64'h0000_0000_0001_0000; tb[3] = 64'd1;
    td[3] = 64'h0000_0000_0000_FFFF; tf[3] = 4'b0010;
    ta[4] = 64'h7FFF_FFFF_FFFF_FFFF; tb[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    td[4] = 64'h8000_0000_0000_0000; tf[4] = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b1, lat);
      n_checks++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL basic_lat[%0d]: latency=%0d required 4", i, lat);
      end
      n_checks++;
      if (d !== td[i]) begin
        n_fail++;
        $display("FAIL basic_d[%0d]: d=%h required %h", i, d, td[i]);
      end
      n_checks++;
      if ({flag_n, flag_z, flag_c, flag_v} !== tf[i]) begin
        n_fail++;
        $display("FAIL basic_nzcv[%0d]: nzcv=%b required %b", i,
                 {flag_n, flag_z, flag_c, flag_v}, tf[i]);
      end
      finish_op();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_hs[%0d]: out_valid=%b in_ready=%b required 0/1", i,
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a = 64'h1234; b = 64'h1234; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'd1; b = 64'd2;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_run_ready[%0d]: in_ready=%b required 0", j, in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_lat: out_valid=%b required 1", out_valid);
    end
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 64'd0 ||
          {flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: ov=%b ir=%b d=%h nzcv=%b required 1/0/0/0110", j,
                 out_valid, in_ready, d, {flag_n, flag_z, flag_c, flag_v});
      end
      @(negedge clk);
      in_valid = 1'b1; a = 64'd7; b = 64'd9;
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          acc_cyc[$];
    logic [63:0] res[$];
    @(negedge clk);
    a = 64'd10; b = 64'd4; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) res.push_back(d);
      if (in_ready) acc_cyc.push_back(i);
      @(posedge clk); #1;
      if (acc_cyc.size() == 1) begin
        a = 64'd100; b = 64'd1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc_cyc.size() != 2 || (acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] != 6)) begin
      n_fail++;
      $display("FAIL b2b_ii: accepts=%0d interval=%0d required 2/6", acc_cyc.size(),
               (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    n_checks++;
    if (res.size() != 2 || (res.size() == 2 && (res[0] !== 64'd6 || res[1] !== 64'd99))) begin
      n_fail++;
      $display("FAIL b2b_results: count=%0d first=%h second=%h required 2/6/63",
               res.size(), (res.size() > 0) ? res[0] : 64'hx,
               (res.size() > 1) ? res[1] : 64'hx);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef SUB64_SBC_EN
  task automatic test_sbc();
    int lat;
    run_op(64'd5, 64'd3, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || d !== 64'd1 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0010) begin
      n_fail++;
      $display("FAIL sbc_cin0: lat=%0d d=%h nzcv=%b required 4/1/0010", lat, d,
               {flag_n, flag_z, flag_c, flag_v});
    end
    finish_op();
    run_op(64'd5, 64'd3, 1'b1, lat);
    n_checks++;
    if (d !== 64'd2 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0010) begin
      n_fail++;
      $display("FAIL sbc_cin1: d=%h nzcv=%b required 2/0010", d,
               {flag_n, flag_z, flag_c, flag_v});
    end
    finish_op();
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a = 64'd5; b = 64'd3; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== 64'd0 ||
        {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: ov=%b ir=%b d=%h nzcv=%b required 0/1/0/0000",
               out_valid, in_ready, d, {flag_n, flag_z, flag_c, flag_v});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd9, 64'd4, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || d !== 64'd5 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_next: lat=%0d d=%h nzcv=%b required 4/5/0010", lat, d,
               {flag_n, flag_z, flag_c, flag_v});
    end
    finish_op();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
`ifdef SUB64_SBC_EN
    test_sbc();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
